mac_regfile: RTL and testbench

MAC_REGFILE -- requirements
Module: mac_regfile

---
 rtl/mac_regfile.sv | 105 ++++++++++
 tb/tb_mac_regfile.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/mac_regfile.sv
// Small register file with a sequential multiply-accumulate engine.
// It supports WRITE, READ, SETLEN and a DOT product over two wrapping address windows.
module mac_regfile #(
  parameter int DW    = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH),
  parameter int ACCW  = 2*DW + AW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [1:0]      cmd_op,
  input  logic [AW-1:0]   cmd_addr,
  input  logic [DW-1:0]   cmd_data,
  output logic            rsp_valid,
  output logic [ACCW-1:0] rsp_data,
  output logic            busy
);

  localparam logic [1:0]    OP_WRITE  = 2'b00;
  localparam logic [1:0]    OP_READ   = 2'b01;
  localparam logic [1:0]    OP_DOT    = 2'b10;
  localparam logic [1:0]    OP_SETLEN = 2'b11;
  localparam logic [AW:0]   LEN_MAX   = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [DW-1:0] DEPTH_D   = DW'(DEPTH);

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state;
  logic [DW-1:0]       mem [DEPTH];
  logic [AW:0]         len;
  logic [AW:0]         cnt;
  logic [AW-1:0]       ptr_a;
  logic [AW-1:0]       ptr_b;
  logic [ACCW-1:0]     acc;
  logic [2*DW-1:0]     prod;
  logic [ACCW-1:0]     sum;

  assign cmd_ready = !busy;

  always_comb begin
    prod = mem[ptr_a] * mem[ptr_b];
    sum  = acc + ACCW'(prod);
  end

  // Commands are only decoded in IDLE, so the memory cannot change under a running DOT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      len       <= LEN_MAX;
      cnt       <= '0;
      ptr_a     <= '0;
      ptr_b     <= '0;
      acc       <= '0;
      state     <= IDLE;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            case (cmd_op)
              OP_WRITE: mem[cmd_addr] <= cmd_data;
              OP_READ: begin
                rsp_valid <= 1'b1;
                rsp_data  <= ACCW'(mem[cmd_addr]);
              end
              OP_DOT: begin
                state <= RUN;
                busy  <= 1'b1;
                acc   <= '0;
                cnt   <= '0;
                ptr_a <= cmd_addr;
                ptr_b <= cmd_data[AW-1:0];
              end
              OP_SETLEN: begin
                if (cmd_data > DEPTH_D) len <= LEN_MAX;
                else if (cmd_data != '0) len <= cmd_data[AW:0];
              end
            endcase
          end
        end
        RUN: begin
          acc   <= sum;
          cnt   <= cnt + CNT_ONE;
          ptr_a <= ptr_a + PTR_ONE;
          ptr_b <= ptr_b + PTR_ONE;
          if (cnt == len - CNT_ONE) begin
            state     <= IDLE;
            busy      <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_data  <= sum;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_regfile.sv
// Directed bench for mac_regfile (DW=8, DEPTH=16) with hand-computed expectations.
module tb_mac_regfile;

  localparam int DW = 8, DEPTH = 16, AW = 4, ACCW = 20;

  logic            clk;
  logic            reset;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [1:0]      cmd_op;
  logic [AW-1:0]   cmd_addr;
  logic [DW-1:0]   cmd_data;
  logic            rsp_valid;
  logic [ACCW-1:0] rsp_data;
  logic            busy;

  int total  = 0;
  int passed = 0;

  mac_regfile #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed === expected) passed++;
    else $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
  endtask

  // Called at a negedge: hold inputs through one rising edge, return at the next negedge.
  task automatic applyStimulus(input logic v, input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cmd_valid = v;
    cmd_op    = op;
    cmd_addr  = a;
    cmd_data  = d;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 2'b00, '0, '0);
  endtask

  task automatic runDot(input string tag, input logic [AW-1:0] a, input logic [AW-1:0] b,
                        input int exp_len, input logic [31:0] exp_sum);
    int cycles;
    applyStimulus(1'b1, 2'b10, a, DW'(b));
    checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
    cycles = 1;
    while (!rsp_valid && cycles < 64) begin
      idle();
      cycles++;
    end
    checkOutput({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    checkOutput({tag, "_latency"}, 32'(cycles), 32'(exp_len + 1));
    checkOutput({tag, "_sum"}, 32'(rsp_data), exp_sum);
    checkOutput({tag, "_busy_low"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int pulses;
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_data = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_ready", 32'(cmd_ready), 32'd1);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_rsp_data", 32'(rsp_data), 32'd0);
    reset = 1'b0;

    applyStimulus(1'b1, 2'b01, 4'd5, 8'd0);
    checkOutput("read5_valid", 32'(rsp_valid), 32'd1);
    checkOutput("read5_data", 32'(rsp_data), 32'd0);
    idle();
    checkOutput("read5_pulse_end", 32'(rsp_valid), 32'd0);

    applyStimulus(1'b1, 2'b00, 4'd3, 8'hA5);
    checkOutput("write_no_rsp", 32'(rsp_valid), 32'd0);
    applyStimulus(1'b1, 2'b01, 4'd3, 8'd0);
    checkOutput("read3_valid", 32'(rsp_valid), 32'd1);
    checkOutput("read3_data", 32'(rsp_data), 32'h00A5);
    applyStimulus(1'b1, 2'b00, 4'd7, 8'h3C);
    applyStimulus(1'b1, 2'b01, 4'd7, 8'd0);
    checkOutput("b2b_read7", 32'(rsp_data), 32'h3C);
    applyStimulus(1'b1, 2'b01, 4'd3, 8'd0);
    checkOutput("b2b_read3_valid", 32'(rsp_valid), 32'd1);
    checkOutput("b2b_read3", 32'(rsp_data), 32'hA5);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 2'b00, AW'(i), DW'(i + 1));
      applyStimulus(1'b1, 2'b00, AW'(i + 8), DW'(i + 5));
    end
    applyStimulus(1'b1, 2'b11, '0, 8'd4);
    applyStimulus(1'b1, 2'b10, 4'd0, 8'd8);
    checkOutput("dot70_busy1", 32'(busy), 32'd1);
    checkOutput("dot70_ready", 32'(cmd_ready), 32'd0);
    applyStimulus(1'b1, 2'b01, 4'd0, 8'd0);
    checkOutput("dot70_read_ignored", 32'(rsp_valid), 32'd0);
    idle();
    idle();
    checkOutput("dot70_busy4", 32'(busy), 32'd1);
    checkOutput("dot70_no_early_rsp", 32'(rsp_valid), 32'd0);
    idle();
    checkOutput("dot70_busy_low", 32'(busy), 32'd0);
    checkOutput("dot70_valid", 32'(rsp_valid), 32'd1);
    checkOutput("dot70_sum", 32'(rsp_data), 32'd70);
    applyStimulus(1'b1, 2'b01, 4'd1, 8'd0);
    checkOutput("accept_on_rsp_valid", 32'(rsp_valid), 32'd1);
    checkOutput("accept_on_rsp_data", 32'(rsp_data), 32'd2);
    idle();
    checkOutput("rsp_hold_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rsp_hold_data", 32'(rsp_data), 32'd2);

    applyStimulus(1'b1, 2'b00, 4'd14, 8'hFF);
    applyStimulus(1'b1, 2'b00, 4'd15, 8'hFF);
    applyStimulus(1'b1, 2'b00, 4'd0, 8'hFF);
    applyStimulus(1'b1, 2'b11, '0, 8'd3);
    runDot("dot_wrap", 4'd14, 4'd14, 3, 32'd195075);

    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 2'b00, AW'(i), 8'hFF);
    applyStimulus(1'b1, 2'b11, '0, 8'd2);
    applyStimulus(1'b1, 2'b11, '0, 8'd0);
    runDot("dot_len0_kept", 4'd5, 4'd9, 2, 32'd130050);
    applyStimulus(1'b1, 2'b11, '0, 8'd200);
    runDot("dot_full", 4'd0, 4'd0, 16, 32'd1040400);

    applyStimulus(1'b1, 2'b10, 4'd0, 8'd0);
    repeat (4) idle();
    checkOutput("abort_busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      idle();
      if (rsp_valid) pulses++;
    end
    checkOutput("abort_no_pulse", 32'(pulses), 32'd0);
    applyStimulus(1'b1, 2'b01, 4'd9, 8'd0);
    checkOutput("abort_mem_cleared", 32'(rsp_data), 32'd0);
    applyStimulus(1'b1, 2'b00, 4'd15, 8'd3);
    runDot("abort_len16", 4'd0, 4'd0, 16, 32'd9);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
